// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - run-time programmable modulo counter with prescaler, one-shot mode and shadowed modulus
module prog_mod_counter #(
  parameter int N        = 4,
  parameter int M        = 10,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         mode,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         m_wr,
  input  logic [N-1:0] m_last,
  output logic [N-1:0] q,
  output logic         tick,
  output logic         done,
  output logic         busy
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0]  T_RESET = N'(M - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [N-1:0]  t_reg;
  logic [N-1:0]  pend_val;
  logic          pend_valid;

  logic          in_run;
  logic          step;
  logic          terminal;
  logic          term_step;
  logic [N-1:0]  m_eff;
  logic [N-1:0]  start_val;
  logic [N-1:0]  load_clamped;
  logic [N-1:0]  t_next;

  // Decode the step/terminal conditions and the candidate values for q and T
  always_comb begin
    in_run       = (state == RUN);
    step         = in_run && en && (presc == PS_LAST) && !stop && !start && !load;
    terminal     = up ? (q == t_reg) : (q == '0);
    term_step    = step && terminal;
    m_eff        = (m_last == '0) ? N'(1) : m_last;
    start_val    = up ? '0 : t_reg;
    load_clamped = (load_val > t_reg) ? t_reg : load_val;
    t_next       = pend_valid ? pend_val : t_reg;
  end

  // Control chain (stop > start > load > step) plus the independent modulus update
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      q          <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      presc      <= '0;
      t_reg      <= T_RESET;
      pend_val   <= '0;
      pend_valid <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
        q     <= start_val;
        presc <= '0;
      end else if (load) begin
        q     <= load_clamped;
        presc <= '0;
      end else if (in_run && en) begin
        if (step) begin
          presc <= '0;
          if (terminal) begin
            tick <= 1'b1;
            if (mode) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              q <= up ? '0 : t_next;
            end
          end else begin
            q <= up ? (q + N'(1)) : (q - N'(1));
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end

      // A pending modulus is consumed by the terminal step; a write in RUN re-arms it
      if (term_step && pend_valid) begin
        t_reg      <= pend_val;
        pend_valid <= 1'b0;
      end
      if (m_wr) begin
        if (in_run) begin
          pend_val   <= m_eff;
          pend_valid <= 1'b1;
        end else begin
          t_reg      <= m_eff;
          pend_valid <= 1'b0;
        end
      end
    end
  end

endmodule
